// File: rtl/systolic_sequencer.sv
// rtl/systolic_sequencer.sv - sequences one matrix job through a systolic-array datapath
//
// Purpose:
//   Accepts an operand stream over a valid/ready handshake and turns each
//   transfer into a one-cycle weight or input load strobe. It then waits out
//   the compute latency, fires the store strobe, and captures the N*N result
//   burst into a show-ahead FIFO that the consumer drains at its own pace.
//
// Optional feature (macro SEQ_DRAIN_TIMEOUT_EN):
//   When defined, a watchdog limits DRAIN to TIMEOUT cycles. On expiry it
//   pulses error and returns to IDLE, and partial results stay in the FIFO.
//   When undefined, DRAIN waits indefinitely and error is tied low.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   start, reuse_weights   job request; reuse_weights skips the weight load
//   in_valid/in_data/in_ready  operand stream
//   sa_data_in             operand to the array, valid with a load strobe
//   sa_load_weights        weight-load strobe
//   sa_load_inputs         input-load strobe
//   sa_store_outputs       store strobe
//   sa_results/sa_valid_out  array result stream, captured only in DRAIN
//   res_valid/res_data/res_ready  result FIFO, show-ahead
//   busy                   state is not IDLE
//   done                   one-cycle pulse when a job completes
//   error                  one-cycle pulse on a DRAIN timeout

module systolic_sequencer #(
    parameter int N              = 2,
    parameter int BITWIDTH       = 4,
    parameter int OUTWIDTH       = 8,
    parameter int COMPUTE_CYCLES = 4,
    parameter int TIMEOUT        = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                reuse_weights,
    input  logic                in_valid,
    input  logic [BITWIDTH-1:0] in_data,
    output logic                in_ready,
    output logic [BITWIDTH-1:0] sa_data_in,
    output logic                sa_load_weights,
    output logic                sa_load_inputs,
    output logic                sa_store_outputs,
    input  logic [OUTWIDTH-1:0] sa_results,
    input  logic                sa_valid_out,
    output logic                res_valid,
    output logic [OUTWIDTH-1:0] res_data,
    input  logic                res_ready,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int NN    = N * N;
    localparam int CNT_W = (NN > 1) ? $clog2(NN) : 1;
    localparam int OCC_W = $clog2(NN + 1);
    localparam int CC_W  = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NN - 1);
    localparam logic [CC_W-1:0]  CC_LAST  = CC_W'(COMPUTE_CYCLES - 1);

    generate
        if (NN < 1) begin : g_bad_n
            $error("N must be at least 1");
        end
        if (COMPUTE_CYCLES < 1) begin : g_bad_compute_cycles
            $error("COMPUTE_CYCLES must be at least 1");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("TIMEOUT must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_X,
        S_COMPUTE,
        S_STORE,
        S_DRAIN
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;      // shared by LOAD_W, LOAD_X and DRAIN
    logic [CC_W-1:0]   cc_cnt;

    logic [OUTWIDTH-1:0] fifo_mem [0:NN-1];
    logic [CNT_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    rd_ptr;
    logic [OCC_W-1:0]    fifo_cnt;

    logic xfer;
    logic push;
    logic pop;
    logic fifo_empty;
    logic last_capture;

    // Every decoded output below is a pure function of the state register,
    // so all of them are glitch-free and zero in reset.
    assign in_ready         = (state == S_LOAD_W) || (state == S_LOAD_X);
    assign busy             = (state != S_IDLE);
    assign sa_store_outputs = (state == S_STORE);

    assign fifo_empty   = (fifo_cnt == '0);
    assign res_valid    = !fifo_empty;
    assign res_data     = fifo_mem[rd_ptr];

    assign xfer         = in_valid && in_ready;
    assign push         = (state == S_DRAIN) && sa_valid_out;
    assign pop          = res_valid && res_ready;
    assign last_capture = push && (cnt == CNT_LAST);

    function automatic logic [CNT_W-1:0] next_ptr(input logic [CNT_W-1:0] p);
        return (p == CNT_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef SEQ_DRAIN_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            cc_cnt          <= '0;
            sa_data_in      <= '0;
            sa_load_weights <= 1'b0;
            sa_load_inputs  <= 1'b0;
            done            <= 1'b0;
`ifdef SEQ_DRAIN_TIMEOUT_EN
            wd_cnt          <= '0;
            error           <= 1'b0;
`endif
        end else begin
            // Strobes and pulses are one cycle unless re-asserted below.
            sa_load_weights <= 1'b0;
            sa_load_inputs  <= 1'b0;
            done            <= 1'b0;
`ifdef SEQ_DRAIN_TIMEOUT_EN
            error           <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    cnt    <= '0;
                    cc_cnt <= '0;
                    // A non-empty FIFO blocks new jobs so a burst can never
                    // overflow it.
                    if (start && fifo_empty) begin
                        state <= reuse_weights ? S_LOAD_X : S_LOAD_W;
                    end
                end

                S_LOAD_W: begin
                    if (xfer) begin
                        sa_data_in      <= in_data;
                        sa_load_weights <= 1'b1;
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= S_LOAD_X;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                S_LOAD_X: begin
                    if (xfer) begin
                        sa_data_in     <= in_data;
                        sa_load_inputs <= 1'b1;
                        if (cnt == CNT_LAST) begin
                            cnt    <= '0;
                            cc_cnt <= '0;
                            state  <= S_COMPUTE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                S_COMPUTE: begin
                    if (cc_cnt == CC_LAST) begin
                        cc_cnt <= '0;
                        state  <= S_STORE;
                    end else begin
                        cc_cnt <= cc_cnt + 1'b1;
                    end
                end

                S_STORE: begin
                    cnt   <= '0;
                    state <= S_DRAIN;
`ifdef SEQ_DRAIN_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end

                S_DRAIN: begin
                    if (push) begin
                        if (last_capture) begin
                            cnt   <= '0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef SEQ_DRAIN_TIMEOUT_EN
                    // A completing capture in the final watchdog cycle wins.
                    if (!last_capture) begin
                        if (wd_cnt == WD_LAST) begin
                            wd_cnt <= '0;
                            cnt    <= '0;
                            error  <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
`endif
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Result FIFO. Simultaneous push and pop keep occupancy fixed; the read
    // and write pointers advance independently, so order is preserved.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < NN; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= sa_results;
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb/tb_systolic_sequencer.sv - directed self-checking bench for systolic_sequencer

module tb_systolic_sequencer;

    localparam int N  = 2;
    localparam int BW = 4;
    localparam int OW = 8;
    localparam int CC = 4;
    localparam int TO = 8;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          reuse_weights;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          in_ready;
    logic [BW-1:0] sa_data_in;
    logic          sa_load_weights;
    logic          sa_load_inputs;
    logic          sa_store_outputs;
    logic [OW-1:0] sa_results;
    logic          sa_valid_out;
    logic          res_valid;
    logic [OW-1:0] res_data;
    logic          res_ready;
    logic          busy;
    logic          done;
    logic          error;

    systolic_sequencer #(
        .N              (N),
        .BITWIDTH       (BW),
        .OUTWIDTH       (OW),
        .COMPUTE_CYCLES (CC),
        .TIMEOUT        (TO)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .reuse_weights    (reuse_weights),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .sa_data_in       (sa_data_in),
        .sa_load_weights  (sa_load_weights),
        .sa_load_inputs   (sa_load_inputs),
        .sa_store_outputs (sa_store_outputs),
        .sa_results       (sa_results),
        .sa_valid_out     (sa_valid_out),
        .res_valid        (res_valid),
        .res_data         (res_data),
        .res_ready        (res_ready),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [OW-1:0] res_tab [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    logic [BW-1:0] w_log [$];
    logic [BW-1:0] x_log [$];
    logic [OW-1:0] pop_log [$];
    int last_x_cyc;
    int store_cyc;
    int store_cnt;
    int done_cnt;
    int err_cnt;

    always @(posedge clk) cyc++;

    // Observe strobes and pops mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (sa_load_weights) w_log.push_back(sa_data_in);
        if (sa_load_inputs) begin
            x_log.push_back(sa_data_in);
            last_x_cyc = cyc;
        end
        if (sa_store_outputs) begin
            store_cnt++;
            store_cyc = cyc;
        end
        if (done)  done_cnt++;
        if (error) err_cnt++;
        if (res_valid && res_ready) pop_log.push_back(res_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        w_log.delete();
        x_log.delete();
        pop_log.delete();
        last_x_cyc = 0;
        store_cyc  = 0;
        store_cnt  = 0;
        done_cnt   = 0;
        err_cnt    = 0;
    endtask

    task automatic send(input logic [BW-1:0] v, input bit gap);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check("in_ready_wait", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic run_job(input bit reuse, input bit gaps, input bit rdy, input int nres);
        int n;
        clear_logs();
        res_ready     = rdy;
        start         = 1'b1;
        reuse_weights = reuse;
        tick();
        start         = 1'b0;
        reuse_weights = 1'b0;
        check("busy_after_start", busy, 1);
        check("in_ready_after_start", in_ready, 1);
        if (!reuse) begin
            for (int i = 0; i < 4; i++) send(BW'(i + 1), gaps);
        end
        for (int i = 0; i < 4; i++) send(BW'(i + 5), gaps);
        n = 0;
        while (!sa_store_outputs && n < 30) begin
            tick();
            n++;
        end
        check("store_seen", sa_store_outputs, 1);
        // Junk offered during STORE must not be captured.
        sa_valid_out = 1'b1;
        sa_results   = 8'hEE;
        tick();
        for (int i = 0; i < nres; i++) begin
            sa_results   = res_tab[i];
            sa_valid_out = 1'b1;
            tick();
        end
        sa_valid_out = 1'b0;
        sa_results   = '0;
    endtask

    task automatic check_loads(input string pfx, input bit exp_w);
        check({pfx, "_w_count"}, w_log.size(), exp_w ? 4 : 0);
        if (exp_w && w_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check({pfx, "_w_data"}, w_log[i], i + 1);
        end
        check({pfx, "_x_count"}, x_log.size(), 4);
        if (x_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check({pfx, "_x_data"}, x_log[i], i + 5);
        end
        check({pfx, "_store_count"}, store_cnt, 1);
        check({pfx, "_store_latency"}, store_cyc - last_x_cyc, CC);
    endtask

    task automatic check_pops(input string pfx);
        check({pfx, "_pop_count"}, pop_log.size(), 4);
        if (pop_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check({pfx, "_pop_data"}, pop_log[i], res_tab[i]);
        end
        check({pfx, "_done_count"}, done_cnt, 1);
        check({pfx, "_fifo_empty"}, res_valid, 0);
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_in_ready"}, in_ready, 0);
        check({pfx, "_sa_data_in"}, sa_data_in, 0);
        check({pfx, "_load_w"}, sa_load_weights, 0);
        check({pfx, "_load_x"}, sa_load_inputs, 0);
        check({pfx, "_store"}, sa_store_outputs, 0);
        check({pfx, "_res_valid"}, res_valid, 0);
        check({pfx, "_res_data"}, res_data, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_error"}, error, 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        reuse_weights = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        sa_results    = '0;
        sa_valid_out  = 1'b0;
        res_ready     = 1'b0;
        clear_logs();
        tick();
        tick();
        check_idle("reset");
        reset_n = 1'b1;
        tick();

        // Full job, back-to-back operands, consumer always ready.
        run_job(1'b0, 1'b0, 1'b1, 4);
        check("full_done", done, 1);
        check("full_busy_end", busy, 0);
        tick(); tick(); tick();
        check_loads("full", 1'b1);
        check_pops("full");

        // One idle cycle between every operand.
        run_job(1'b0, 1'b1, 1'b1, 4);
        check("gap_done", done, 1);
        tick(); tick(); tick();
        check_loads("gap", 1'b1);
        check_pops("gap");

        // Reuse weights: straight to LOAD_X.
        run_job(1'b1, 1'b0, 1'b1, 4);
        check("reuse_done", done, 1);
        tick(); tick(); tick();
        check_loads("reuse", 1'b0);
        check_pops("reuse");

        // Consumer stalled through DRAIN; start blocked until FIFO drains.
        run_job(1'b0, 1'b0, 1'b0, 4);
        check("stall_done", done, 1);
        check("stall_busy_end", busy, 0);
        check("stall_res_valid", res_valid, 1);
        check("stall_head", res_data, 8'h11);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("stall_start_ignored_full", busy, 0);
        for (int i = 0; i < 3; i++) begin
            res_ready = 1'b1;
            check("stall_pop_data", res_data, res_tab[i]);
            tick();
        end
        res_ready = 1'b0;
        check("stall_last_head", res_data, 8'h44);
        check("stall_last_valid", res_valid, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("stall_start_ignored_one", busy, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("stall_drained", res_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("stall_start_accepted", busy, 1);

        // Continue that job into COMPUTE, then reset for one cycle.
        for (int i = 0; i < 8; i++) send(BW'(i + 1), 1'b0);
        check("rst_in_compute_busy", busy, 1);
        check("rst_in_compute_ready", in_ready, 0);
        clear_logs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_idle("midreset");
        for (int i = 0; i < CC + 4; i++) tick();
        check("midreset_no_store", store_cnt, 0);
        check("midreset_still_idle", busy, 0);

`ifdef SEQ_DRAIN_TIMEOUT_EN
        // Array returns only three results; watchdog must fire.
        run_job(1'b0, 1'b0, 1'b0, 3);
        for (int n = 0; n < 20 && err_cnt == 0; n++) tick();
        tick();
        check("wd_error_pulses", err_cnt, 1);
        check("wd_no_done", done_cnt, 0);
        check("wd_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            check("wd_res_valid", res_valid, 1);
            check("wd_res_data", res_data, res_tab[i]);
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
        check("wd_fifo_empty", res_valid, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Controller that sequences one matrix job through the systolic-array datapath (`BITWIDTH`-bit operand port, `load_weights`/`load_inputs`/`store_outputs` strobes, `OUTWIDTH`-bit `results` with `valid_out`). It accepts an operand stream over a valid/ready handshake and issues the weight and input load strobes. It waits out the compute latency, triggers the result store, and captures the result burst into a local FIFO that the consumer drains at its own pace. The block sits between the chip pins or host logic and the array instance.

## Interface
- `N`, 2: array dimension; one job loads N*N weights and N*N inputs, and returns N*N results.
- `BITWIDTH`, 4: operand width.
- `OUTWIDTH`, 8: result width.
- `COMPUTE_CYCLES`, 4: wait cycles between the last input load and the store strobe (≥1).
- `TIMEOUT`, 64: DRAIN watchdog limit in cycles; used only when `SEQ_DRAIN_TIMEOUT_EN` is defined.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a new job; a single-cycle pulse is enough.
- `reuse_weights`  in  1  sampled with an accepted `start`; when 1, skip the weight load.
- `in_valid`  in  1  operand stream valid.
- `in_data`  in  BITWIDTH  operand nibble.
- `in_ready`  out  1  operand stream ready.
- `sa_data_in`  out  BITWIDTH  operand to the array.
- `sa_load_weights`  out  1  weight-load strobe.
- `sa_load_inputs`  out  1  input-load strobe.
- `sa_store_outputs`  out  1  store strobe.
- `sa_results`  in  OUTWIDTH  array result.
- `sa_valid_out`  in  1  array result valid.
- `res_valid`  out  1  FIFO not empty.
- `res_data`  out  OUTWIDTH  FIFO head (show-ahead).
- `res_ready`  in  1  consumer pop.
- `busy`  out  1  high when the state is not IDLE.
- `done`  out  1  one-cycle pulse when a job completes.
- `error`  out  1  one-cycle pulse on a DRAIN timeout.

## Operation
- States: IDLE, LOAD_W, LOAD_X, COMPUTE, STORE, DRAIN.
- Start acceptance:
  - `start` is accepted only when the state is IDLE and the FIFO is empty. Otherwise it is ignored; requests are not queued.
  - An accepted start goes to LOAD_X if `reuse_weights`=1, else to LOAD_W.
- LOAD_W and LOAD_X:
  - `in_ready`=1. A transfer occurs when `in_valid`&&`in_ready`.
  - Each transfer registers `sa_data_in`<=`in_data` and sets the matching strobe for exactly the next cycle.
  - Cycles with no transfer drive the strobe low; the array holds.
  - A shared counter runs 0..N*N-1 and resets on each state change.
  - The N*N-th transfer moves LOAD_W→LOAD_X or LOAD_X→COMPUTE.
  - `in_ready`=0 in all other states.
- COMPUTE: stays for exactly `COMPUTE_CYCLES` cycles, then moves to STORE.
- STORE:
  - Lasts exactly one cycle, then moves to DRAIN.
  - `sa_store_outputs` is high in every STORE cycle and in no other cycle.
- DRAIN:
  - Every cycle with `sa_valid_out`=1 pushes `sa_results` into the FIFO.
  - After the N*N-th push: state→IDLE and `done`=1 for that one cycle.
  - `sa_valid_out` is ignored outside DRAIN.
- FIFO:
  - Depth N*N, show-ahead.
  - A pop occurs when `res_valid`&&`res_ready`.
  - Push and pop in the same cycle leave occupancy unchanged and preserve data order.
  - Overflow cannot occur because the start-acceptance rule forbids it. A pop when empty has no effect.
- Widths: `res_data` is `sa_results` unmodified. The counters are sized for N*N, `COMPUTE_CYCLES` and `TIMEOUT`.

## Timing
- Reset values: every output is 0, the state is IDLE, all counters are 0 and the FIFO is empty.
  - A reset mid-job aborts the job, flushes the FIFO, and drops any strobe on the next edge.
- A start accepted at cycle 0 gives `busy`=1 and `in_ready`=1 at cycle 1.
- A transfer at cycle k gives the strobe and `sa_data_in` valid at cycle k+1. The load latency is exactly 1 cycle.
- Last input transfer at cycle t:
  - COMPUTE spans cycles t+1 .. t+COMPUTE_CYCLES. The final `sa_load_inputs` pulse at t+1 overlaps COMPUTE.
  - STORE is at t+COMPUTE_CYCLES+1.
  - DRAIN starts at t+COMPUTE_CYCLES+2.
- The N*N-th capture at cycle d gives `done`=1 and `busy`=0 at d+1, and `res_valid` no later than d+1.
- A push at cycle p makes the data visible on `res_data` at p+1 if the FIFO was empty.

## Configuration
- `SEQ_DRAIN_TIMEOUT_EN` defined:
  - A DRAIN watchdog counts cycles since entering DRAIN.
  - On reaching `TIMEOUT` without N*N captures: `error`=1 for one cycle, state→IDLE, no `done`.
  - Results already captured stay in the FIFO.
- Not defined:
  - DRAIN waits indefinitely.
  - `error` is tied to 0 and no watchdog logic is synthesized.

## Test plan
- Full job, N=2, COMPUTE_CYCLES=4:
  - Stimulus: weights 1,2,3,4; inputs 5,6,7,8, back-to-back; array returns 0x11,0x22,0x33,0x44; `res_ready`=1.
  - Required: four `sa_load_weights` pulses carrying 1..4, then four `sa_load_inputs` pulses carrying 5..8, `sa_store_outputs` exactly 5 cycles after the last input transfer, `res_data` sequence 0x11..0x44, and one `done` pulse.
- `in_valid` with 1-cycle gaps between operands → no strobe during gap cycles; the operand order is unchanged.
- `reuse_weights`=1 with the start → no `sa_load_weights` pulse; LOAD_X is entered at cycle 1.
- `res_ready`=0 during DRAIN:
  - FIFO holds 4 results and `done` pulses.
  - A new `start` is ignored until all 4 results are popped; the next `start` is accepted.
- Reset mid-job: `reset_n`=0 for 1 cycle in COMPUTE → next cycle all outputs are 0, state IDLE, FIFO empty.
- With `SEQ_DRAIN_TIMEOUT_EN`, TIMEOUT=8, array returns 3 results → `error` pulses, no `done`, 3 results are poppable, and `busy`=0.
